// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and integer duty percent of an asynchronous PWM input
// Ports: clk/nrst (async active-low) clock and reset; en measurement enable;
//   pwm_in async waveform; period_cnt/high_cnt last result in clk cycles;
//   duty_percent floor(high*100/period); meas_valid result-update pulse;
//   overrun dropped-period pulse; stuck/stuck_level no-edge flag and level.
module pwm_capture #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000000
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [6:0]       duty_percent,
  output logic             meas_valid,
  output logic             overrun,
  output logic             stuck,
  output logic             stuck_level
);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int NW = CNT_W + 7;
  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;
  state_t state, nstate;
  logic [SYNC_STAGES-1:0] sync;
  logic s, s_d, rise, fall, timeout, close, busy, ge;
  logic [CNT_W-1:0] cnt, hi, p_lat, h_lat;
  logic [IW-1:0] idle;
  logic [NW-1:0] rem, dsh;
  logic [5:0] q;
  logic [3:0] step;
  assign s     = sync[SYNC_STAGES-1];
  assign rise  = s & ~s_d;
  assign fall  = ~s & s_d;
  assign close = state == LOW && rise;
  assign busy  = step != 4'd0;
  assign ge    = rem >= dsh;
  // a saturated edge counter is treated exactly like an edge timeout
  assign timeout = state != IDLE && ((idle == IW'(TIMEOUT) && !(rise | fall)) || &cnt);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= IDLE;
    else state <= nstate;
  always_comb begin
    nstate = state;
    if (!en) nstate = IDLE;
    else if (state == IDLE || timeout) nstate = ARM;
    else if (rise && state != HIGH) nstate = HIGH;
    else if (fall && state == HIGH) nstate = LOW;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      sync <= '0;
      s_d <= 1'b0;
      cnt <= '0;
      hi <= '0;
      p_lat <= '0;
      h_lat <= '0;
      idle <= '0;
      rem <= '0;
      dsh <= '0;
      q <= '0;
      step <= '0;
      period_cnt <= '0;
      high_cnt <= '0;
      duty_percent <= '0;
      meas_valid <= 1'b0;
      overrun <= 1'b0;
      stuck <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      s_d <= s;
      meas_valid <= 1'b0;
      overrun <= 1'b0;
      if (!en || state == IDLE) begin
        cnt <= '0;
        idle <= '0;
        step <= '0;
      end else if (timeout) begin
        cnt <= '0;
        idle <= '0;
        step <= '0;
        stuck <= 1'b1;
        stuck_level <= s;
        meas_valid <= 1'b1;
        period_cnt <= '0;
        high_cnt <= '0;
        duty_percent <= s ? 7'd100 : 7'd0;
      end else begin
        idle <= (rise | fall) ? '0 : idle + 1'b1;
        cnt <= rise ? CNT_W'(1) : state == ARM ? '0 : cnt + 1'b1;
        if (fall && state == HIGH) hi <= cnt;
        overrun <= close && busy;
        // load cycle, then 7 restoring steps; step 1 is a trailing busy cycle
        if (close && !busy) begin
          rem <= NW'(hi) * NW'(100);
          dsh <= {1'b0, cnt, 6'b0};
          p_lat <= cnt;
          h_lat <= hi;
          q <= '0;
          step <= 4'd8;
        end else if (busy) begin
          step <= step - 4'd1;
          if (step >= 4'd2) begin
            rem <= ge ? rem - dsh : rem;
            dsh <= dsh >> 1;
            q <= {q[4:0], ge};
          end
          if (step == 4'd2) begin
            period_cnt <= p_lat;
            high_cnt <= h_lat;
            duty_percent <= {q, ge};
            meas_valid <= 1'b1;
            stuck <= 1'b0;
          end
        end
      end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and randomized checks of pwm_capture against an arithmetic duty model
module tb_pwm_capture;
  logic clk = 1'b0, nrst = 1'b0, en = 1'b0, pwm_in = 1'b0;
  logic [31:0] f_period, f_high, s_period, s_high;
  logic [6:0] f_duty, s_duty;
  logic f_mv, f_ovr, f_stuck, f_lvl, s_mv, s_ovr, s_stuck, s_lvl;
  typedef struct {longint per; longint hi; longint duty; longint stk; longint lvl; longint cyc;} res_t;
  res_t fq[$], sq[$];
  longint rise_q[$];
  int vecs = 0, miscmp = 0, fovr = 0;
  longint cyc = 0;
  always #5 clk = ~clk;
  pwm_capture #(.TIMEOUT(1000)) u_fast (
    .clk(clk), .nrst(nrst), .en(en), .pwm_in(pwm_in), .period_cnt(f_period), .high_cnt(f_high),
    .duty_percent(f_duty), .meas_valid(f_mv), .overrun(f_ovr), .stuck(f_stuck), .stuck_level(f_lvl));
  pwm_capture u_slow (
    .clk(clk), .nrst(nrst), .en(en), .pwm_in(pwm_in), .period_cnt(s_period), .high_cnt(s_high),
    .duty_percent(s_duty), .meas_valid(s_mv), .overrun(s_ovr), .stuck(s_stuck), .stuck_level(s_lvl));
  task automatic check(input string tag, input longint obs, input longint exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic sample();
    @(negedge clk);
    if (f_mv) fq.push_back('{per: f_period, hi: f_high, duty: f_duty, stk: f_stuck, lvl: f_lvl, cyc: cyc});
    if (s_mv) sq.push_back('{per: s_period, hi: s_high, duty: s_duty, stk: s_stuck, lvl: s_lvl, cyc: cyc});
    if (f_ovr) fovr++;
    cyc++;
  endtask
  task automatic step(input bit v);
    @(posedge clk);
    #1 pwm_in = v;
    sample();
  endtask
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask
  task automatic clear();
    fq.delete();
    sq.delete();
    rise_q.delete();
    fovr = 0;
  endtask
  task automatic drive(input int per, input int hi, input int n);
    for (int p = 0; p < n; p++)
      for (int c = 0; c < per; c++) begin
        if (c == 0) rise_q.push_back(cyc);
        step(c < hi);
      end
  endtask
  task automatic restart();
    en = 1'b0;
    idle_cycles(3);
    en = 1'b1;
    idle_cycles(3);
    clear();
  endtask
  task automatic check_results(input string tag, input bit slow, input longint per, input longint hi, input int n);
    res_t r[$];
    if (slow) r = sq;
    else r = fq;
    check({tag, "_count"}, r.size(), n);
    foreach (r[i]) begin
      check({tag, "_period"}, r[i].per, per);
      check({tag, "_high"}, r[i].hi, hi);
      check({tag, "_duty"}, r[i].duty, (hi * 100) / per);
      check({tag, "_stuck"}, r[i].stk, 0);
    end
  endtask
  initial begin
    int per, hi, n;
    repeat (3) sample();
    check("rst_period", f_period, 0);
    check("rst_high", f_high, 0);
    check("rst_duty", f_duty, 0);
    check("rst_valid", f_mv, 0);
    check("rst_overrun", f_ovr, 0);
    check("rst_stuck", f_stuck, 0);
    check("rst_level", f_lvl, 0);
    nrst = 1'b1;
    restart();
    drive(100, 25, 4);
    idle_cycles(15);
    check_results("p100h25", 0, 100, 25, 3);
    if (fq.size() > 0 && rise_q.size() > 1) check("latency", fq[0].cyc - rise_q[1], 2 + 8);
    else check("latency_present", 0, 1);
    check("p100h25_overrun", fovr, 0);
    for (int k = 0; k < 4; k++) begin
      per = $urandom_range(400, 9);
      hi = $urandom_range(per - 1, 1);
      restart();
      drive(per, hi, 3);
      idle_cycles(15);
      check_results("random", 0, per, hi, 2);
    end
    restart();
    drive(100, 25, 2);
    repeat (10) step(1'b1);
    nrst = 1'b0;
    #1;
    check("midrst_period", f_period, 0);
    check("midrst_high", f_high, 0);
    check("midrst_duty", f_duty, 0);
    check("midrst_valid", f_mv, 0);
    idle_cycles(3);
    nrst = 1'b1;
    idle_cycles(3);
    clear();
    drive(100, 25, 3);
    idle_cycles(15);
    check_results("after_rst", 0, 100, 25, 2);
    restart();
    drive(3000, 1999, 2);
    idle_cycles(15);
    check_results("p3000h1999", 1, 3000, 1999, 1);
    restart();
    drive(10, 1, 3);
    idle_cycles(15);
    check_results("p10h1", 0, 10, 1, 2);
    check("p10h1_overrun", fovr, 0);
    restart();
    drive(7, 3, 9);
    idle_cycles(15);
    check_results("p7h3", 0, 7, 3, 4);
    check("p7h3_overrun", fovr, 4);
    restart();
    drive(9, 4, 5);
    idle_cycles(15);
    check_results("p9h4", 0, 9, 4, 4);
    check("p9h4_overrun", fovr, 0);
    restart();
    n = 0;
    while (fq.size() == 0 && n < 1500) begin
      step(1'b1);
      n++;
    end
    check("timeout_window", (n >= 1000 && n <= 1010) ? 1 : 0, 1);
    if (fq.size() > 0) begin
      check("timeout_period", fq[0].per, 0);
      check("timeout_high", fq[0].hi, 0);
      check("timeout_duty", fq[0].duty, 100);
      check("timeout_stuck", fq[0].stk, 1);
      check("timeout_level", fq[0].lvl, 1);
    end else check("timeout_present", 0, 1);
    check("stuck_level_hold", f_stuck, 1);
    clear();
    idle_cycles(5);
    drive(100, 50, 3);
    idle_cycles(15);
    check_results("recover", 0, 100, 50, 2);
    check("recover_stuck_now", f_stuck, 0);
    restart();
    drive(80, 60, 3);
    idle_cycles(15);
    check_results("pre_en", 0, 80, 60, 2);
    clear();
    repeat (5) step(1'b1);
    en = 1'b0;
    drive(80, 20, 2);
    idle_cycles(15);
    check("en_low_valids", fq.size(), 0);
    check("en_low_period", f_period, 80);
    check("en_low_high", f_high, 60);
    check("en_low_duty", f_duty, 75);
    en = 1'b1;
    idle_cycles(3);
    clear();
    drive(50, 10, 3);
    idle_cycles(15);
    check_results("reenable", 0, 50, 10, 2);
    if (fq.size() > 0 && rise_q.size() > 1) check("reenable_first", fq[0].cyc - rise_q[1], 2 + 8);
    else check("reenable_present", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
